// File: rtl/button_conditioner_pkg.sv
// Shared alarm-clock button definitions: button indices, repeat FSM
// states, default auto-repeat mask and a small constant helper.
package button_conditioner_pkg;

  localparam int unsigned BTN_CENTER = 0;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_RIGHT  = 2;
  localparam int unsigned BTN_UP     = 3;
  localparam int unsigned BTN_DOWN   = 4;

  localparam int unsigned NUM_BTN_DEFAULT = 5;

  // Only the up/down adjust buttons auto-repeat by default.
  localparam logic [NUM_BTN_DEFAULT-1:0] DEFAULT_REPEAT_MASK = 5'b11000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button channel: 2-FF synchronizer, debounce counter, press pulse
// and optional auto-repeat FSM.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   btn_raw    - asynchronous bouncing level, 1 = pressed
//   btn_level  - debounced level
//   btn_pulse  - one-cycle press / repeat strobe
module debounce_cell
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 20_000_000,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  // Counter only needs to hold DEBOUNCE_CYCLES-1; it clears on reaching the limit.
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD));

  logic          sync1_q, sync1_d;
  logic          s_q, s_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  rpt_state_e    state_q, state_d;
  logic          rise, fall;

  // Next-state logic for synchronizer, debounce, pulse and repeat FSM.
  always_comb begin
    sync1_d = btn_raw;
    s_d     = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    state_d = state_q;
    timer_d = timer_q;
    pulse_d = 1'b0;
    rise    = 1'b0;
    fall    = 1'b0;

    // Count while the synchronized level disagrees; any agreement clears.
    if (s_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = s_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    rise    = ~level_q & level_d;
    fall    = level_q & ~level_d;
    pulse_d = rise;

    if (REPEAT_EN) begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = HOLD;
            timer_d = '0;
          end
        end
        HOLD: begin
          if (timer_q == TW'(REPEAT_DELAY - 1)) begin
            pulse_d = 1'b1;
            timer_d = '0;
            state_d = REPEAT;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        REPEAT: begin
          if (timer_q == TW'(REPEAT_PERIOD - 1)) begin
            pulse_d = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase

      // A release overrides any terminal count in the same cycle.
      if (fall) begin
        state_d = IDLE;
        timer_d = '0;
        pulse_d = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      timer_q <= '0;
      state_q <= IDLE;
    end else begin
      sync1_q <= sync1_d;
      s_q     <= s_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      state_q <= state_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton front end: one debounce_cell per button, outputs concatenated.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   btn_raw    - raw button levels (0 center, 1 left, 2 right, 3 up, 4 down)
//   btn_level  - debounced levels
//   btn_pulse  - one-cycle press / auto-repeat strobes
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned          N_BTN           = 5,
  parameter int unsigned          DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned          REPEAT_DELAY    = 50_000_000,
  parameter int unsigned          REPEAT_PERIOD   = 20_000_000,
  parameter logic [N_BTN-1:0]     REPEAT_MASK     = N_BTN'(DEFAULT_REPEAT_MASK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw[i]),
      .btn_level (btn_level[i]),
      .btn_pulse (btn_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8 and a 10 ns clock.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  logic       clk;
  logic       rst;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;

  int checks;
  int failures;
  int cnt_a;
  int cnt_b;

  button_conditioner #(
    .N_BTN           (5),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8),
    .REPEAT_MASK     (5'b11000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    btn_raw  = '0;

    // Reset state
    step();
    step();
    chk("reset_level", 32'(btn_level), 32'h0);
    chk("reset_pulse", 32'(btn_pulse), 32'h0);
    rst = 1'b0;
    step();
    step();

    // 1: clean center press held 10 cycles; rise at edge 6, fall at edge 16
    btn_raw = 5'b00001;
    for (int e = 1; e <= 20; e++) begin
      step();
      chk($sformatf("t1_pulse_e%0d", e), 32'(btn_pulse), (e == 6) ? 32'h1 : 32'h0);
      chk($sformatf("t1_level_e%0d", e), 32'(btn_level), (e >= 6 && e < 16) ? 32'h1 : 32'h0);
      if (e == 10) btn_raw = '0;
    end

    // 2: bounce on left is rejected
    for (int e = 0; e < 30; e++) begin
      btn_raw[BTN_LEFT] = (e < 2) || (e >= 4 && e < 6);
      step();
      chk($sformatf("t2_level_e%0d", e), 32'(btn_level[BTN_LEFT]), 32'h0);
      chk($sformatf("t2_pulse_e%0d", e), 32'(btn_pulse[BTN_LEFT]), 32'h0);
    end
    btn_raw = '0;
    step();

    // 3: up auto-repeat; press at 6, repeats 26,34,42,50,58; release sampled
    //    at edge 61, level falls at 66 where the repeat terminal count loses
    btn_raw[BTN_UP] = 1'b1;
    for (int e = 1; e <= 80; e++) begin
      step();
      chk($sformatf("t3_pulse_e%0d", e), 32'(btn_pulse),
          (e == 6 || e == 26 || e == 34 || e == 42 || e == 50 || e == 58) ? 32'h8 : 32'h0);
      chk($sformatf("t3_level_e%0d", e), 32'(btn_level), (e >= 6 && e < 66) ? 32'h8 : 32'h0);
      if (e == 60) btn_raw = '0;
    end

    // 4: right is not repeat-enabled; exactly one pulse over a long hold
    cnt_a = 0;
    cnt_b = 0;
    btn_raw[BTN_RIGHT] = 1'b1;
    for (int e = 1; e <= 80; e++) begin
      step();
      if (btn_pulse[BTN_RIGHT]) cnt_a++;
      if ((btn_pulse & 5'b11011) != 5'b0) cnt_b++;
      if (e == 60) btn_raw = '0;
    end
    chk("t4_right_pulses", 32'(cnt_a), 32'd1);
    chk("t4_other_pulses", 32'(cnt_b), 32'd0);
    chk("t4_level_released", 32'(btn_level), 32'h0);

    // 5a: left and right pressed together pulse on the same edge
    btn_raw = 5'b00110;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk($sformatf("t5a_pulse_e%0d", e), 32'(btn_pulse), (e == 6) ? 32'h6 : 32'h0);
    end
    btn_raw = '0;
    for (int e = 0; e < 10; e++) step();
    chk("t5a_level_released", 32'(btn_level), 32'h0);

    // 5b: reset mid-HOLD on up, then up held through reset release
    btn_raw[BTN_UP] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      chk($sformatf("t5b_pre_pulse_e%0d", e), 32'(btn_pulse), (e == 6) ? 32'h8 : 32'h0);
    end
    rst = 1'b1;
    step();
    chk("t5b_rst_level", 32'(btn_level), 32'h0);
    chk("t5b_rst_pulse", 32'(btn_pulse), 32'h0);
    step();
    rst = 1'b0;
    for (int e = 1; e <= 27; e++) begin
      step();
      chk($sformatf("t5b_post_pulse_e%0d", e), 32'(btn_pulse),
          (e == 6 || e == 26) ? 32'h8 : 32'h0);
      chk($sformatf("t5b_post_level_e%0d", e), 32'(btn_level), (e >= 6) ? 32'h8 : 32'h0);
    end
    btn_raw = '0;
    for (int e = 0; e < 10; e++) step();
    chk("t5b_final_level", 32'(btn_level), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage between the board pushbuttons and the alarm-clock control FSM. It synchronizes each raw button, debounces it and emits a single-cycle press pulse on every debounced rising edge. For the up/down adjust buttons it also emits auto-repeat pulses while the button is held. Its pulse outputs drive the FSM's left/right/center inputs and the up/down adjust path directly.

## Interface
Parameters:
- N_BTN, 5: number of buttons. Bit map: 0 center, 1 left, 2 right, 3 up, 4 down.
- DEBOUNCE_CYCLES, 2_000_000: consecutive cycles a new synchronized level must hold before it is accepted. Minimum 2.
- REPEAT_DELAY, 50_000_000: hold cycles from the press pulse to the first repeat pulse. Minimum 2.
- REPEAT_PERIOD, 20_000_000: cycles between successive repeat pulses. Minimum 2.
- REPEAT_MASK, 5'b11000: per-button auto-repeat enable.

Ports:
- clk, input, 1: system clock. The block has one clock.
- rst, input, 1: synchronous reset, active-high.
- btn_raw, input, N_BTN: asynchronous, bouncing button levels, 1 = pressed.
- btn_level, output, N_BTN: debounced button level.
- btn_pulse, output, N_BTN: one-cycle press/repeat strobe.

## Operation
- Per bit, a 2-FF synchronizer turns btn_raw into s.
- **Debounce:**
  - While s == btn_level, the counter is 0.
  - While s != btn_level, the counter increments.
  - On the cycle the counter would reach DEBOUNCE_CYCLES, btn_level takes s and the counter clears.
  - If s returns to btn_level before the count completes, the counter clears and btn_level is unchanged. Glitches shorter than DEBOUNCE_CYCLES are fully rejected.
- **Press pulse:** btn_pulse[i] = 1 for exactly one cycle, on the same edge at which btn_level[i] goes 0→1. A release produces no pulse.
- **Repeat FSM** (only for bits with REPEAT_MASK set; other bits stay in IDLE):
  - IDLE: on btn_level rise (press pulse issued), go to HOLD with timer=0.
  - HOLD: timer increments. When timer == REPEAT_DELAY-1, pulse, timer=0, go to REPEAT.
  - REPEAT: timer increments. When timer == REPEAT_PERIOD-1, pulse and timer=0.
  - From any state: when btn_level falls, go to IDLE, timer=0, no pulse.
- Timer width is clog2(max(REPEAT_DELAY, REPEAT_PERIOD)). It never wraps, because it clears on terminal count.
- Buttons are fully independent. Several btn_pulse bits may assert in the same cycle; arbitration belongs to the consumer FSM.
- At most one pulse per button per cycle.

## Timing
- **Reset** (rst high at an edge): synchronizer FFs, btn_level, btn_pulse, all counters = 0; all FSMs = IDLE. Outputs read 0 on the first edge after reset is sampled.
- **Reset mid-debounce or mid-repeat:** all progress is discarded; no pulse is emitted in the reset cycle.
- **Button held across reset release:** treated as a new press. One pulse is emitted after the normal latency, then repeat timing starts.
- **Press latency:** let edge 1 be the first edge that samples btn_raw=1 (steady). btn_level and btn_pulse rise at edge 2+DEBOUNCE_CYCLES.
- **Release latency:** btn_level falls at edge 2+DEBOUNCE_CYCLES after the first edge that samples 0.
- **Repeat spacing:**
  - First repeat pulse: REPEAT_DELAY cycles after the press pulse.
  - Subsequent repeat pulses: every REPEAT_PERIOD cycles.
- **Release on a terminal-count cycle:** the release wins and no pulse is emitted.

## Structure
- **Shared package (alarm clock):**
  - Button index constants BTN_CENTER, BTN_LEFT, BTN_RIGHT, BTN_UP, BTN_DOWN.
  - Repeat state enum IDLE/HOLD/REPEAT.
  - Default REPEAT_MASK.
- **Sub-module debounce_cell:** one instance per bit via generate. It contains the synchronizer, debounce counter, pulse logic and the repeat FSM, gated by REPEAT_EN.
- The top level only instantiates N_BTN cells and concatenates their outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8 and a 10 ns clock.
1. **Clean center press:** btn_raw[0] goes 0→1 and is held 100 ns → btn_level[0] and btn_pulse[0] rise at edge 6; the pulse is one cycle wide; btn_pulse[1..4] stay 0.
2. **Bounce rejection:** btn_raw[1] toggles 1,0,1,0 at 2-cycle intervals, then stays 0 → btn_level[1] and btn_pulse[1] never assert.
3. **Auto-repeat:** hold btn_raw[3] for 60 cycles → press pulse at cycle P, repeats at P+20, P+28, P+36…; release → no further pulses; btn_level[3] falls 6 edges after the release is sampled.
4. **No repeat on masked-off button:** hold btn_raw[2] for 60 cycles → exactly one pulse.
5. **Simultaneous and reset:**
   - Press left and right on the same cycle → both pulses assert on the same edge.
   - Assert rst mid-HOLD on up → outputs are 0 the next cycle.
   - Keep up held through reset release → one new press pulse 6 edges after reset deasserts.
